// File: rtl/dpram_port_arbiter_pkg.sv
// dpram_arb_pkg: shared constants and helpers for the dual-port RAM arbiter.
//   DEF_DATA_WIDTH / DEF_ADDR_WIDTH / DEF_NUM_REQ : default parameter values
//   id_width(n)                                   : requester index width
package dpram_arb_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_NUM_REQ    = 4;

  // Index width for n requesters; never below 1 bit.
  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a registered priority pointer.
//   clk, rst : clock, synchronous active-high reset
//   req      : per-requester request
//   gnt      : one-hot grant (combinational), forced to 0 during reset
//   gnt_id   : index of the granted requester (0 when none)
module rr_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int ID_WIDTH = id_width(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  gnt,
  output logic [ID_WIDTH-1:0] gnt_id
);

  localparam logic [ID_WIDTH:0] NREQ_W = (ID_WIDTH+1)'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0] LAST = ID_WIDTH'(NUM_REQ-1);

  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic                any_gnt;
  logic [ID_WIDTH:0]   sum;
  logic [ID_WIDTH-1:0] idx;

  // Cyclic search starting at ptr_q; one extra bit absorbs the wrap.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    any_gnt = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_q} + (ID_WIDTH+1)'(i);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      idx = sum[ID_WIDTH-1:0];
      if (!any_gnt && !rst && req[idx]) begin
        any_gnt  = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = idx;
      end
    end
  end

  assign ptr_d = (gnt_id == LAST) ? '0 : gnt_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst)          ptr_q <= '0;
    else if (any_gnt) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// dpram_port_arbiter: shares one RAM write port and one RAM read port among
// NUM_REQ requesters with independent round-robin arbitration per side.
//   clk, rst                      : clock, synchronous active-high reset
//   wr_req_i/wr_addr_i/wr_data_i  : packed per-requester write requests
//   wr_gnt_o                      : one-hot write grant (combinational)
//   rd_req_i/rd_addr_i            : packed per-requester read requests
//   rd_gnt_o                      : one-hot read grant (combinational)
//   rd_valid_o/rd_id_o/rd_data_o  : registered read response, tagged by requester
//   ram_*                         : direct RAM port drive; ram_data_i is the
//                                   RAM's combinational read data
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ID_WIDTH   = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            wr_req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data_i,
  output logic [NUM_REQ-1:0]            wr_gnt_o,
  input  logic [NUM_REQ-1:0]            rd_req_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NUM_REQ-1:0]            rd_gnt_o,
  output logic                          rd_valid_o,
  output logic [ID_WIDTH-1:0]           rd_id_o,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  output logic                          ram_write_en_o,
  output logic [ADDR_WIDTH-1:0]         ram_write_addr_o,
  output logic [DATA_WIDTH-1:0]         ram_data_o,
  output logic                          ram_read_en_o,
  output logic [ADDR_WIDTH-1:0]         ram_read_addr_o,
  input  logic [DATA_WIDTH-1:0]         ram_data_i
);

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] wr_addr_a, rd_addr_a;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wr_data_a;
  logic [ID_WIDTH-1:0]                wr_id, rd_id;

  assign wr_addr_a = wr_addr_i;
  assign wr_data_a = wr_data_i;
  assign rd_addr_a = rd_addr_i;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_wr_arb (
    .clk(clk), .rst(rst), .req(wr_req_i), .gnt(wr_gnt_o), .gnt_id(wr_id)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_rd_arb (
    .clk(clk), .rst(rst), .req(rd_req_i), .gnt(rd_gnt_o), .gnt_id(rd_id)
  );

  // Write side: commit happens at the grant edge; idle bus is driven to 0.
  assign ram_write_en_o   = |wr_gnt_o;
  assign ram_write_addr_o = ram_write_en_o ? wr_addr_a[wr_id] : '0;
  assign ram_data_o       = ram_write_en_o ? wr_data_a[wr_id] : '0;

  assign ram_read_en_o    = |rd_gnt_o;
  assign ram_read_addr_o  = ram_read_en_o ? rd_addr_a[rd_id] : '0;

  // Read response register: data/id hold when no read is granted.
  logic                  rd_valid_q;
  logic [ID_WIDTH-1:0]   rd_id_q;
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= ram_read_en_o;
      if (ram_read_en_o) begin
        rd_id_q   <= rd_id;
        rd_data_q <= ram_data_i;
      end
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_id_o    = rd_id_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
module tb_dpram_port_arbiter;
  localparam int DW = 32, AW = 10, NR = 4, IW = 2;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]    wr_req, rd_req, wr_gnt, rd_gnt;
  logic [NR*AW-1:0] wr_addr, rd_addr;
  logic [NR*DW-1:0] wr_data;
  logic             rd_valid, ram_we, ram_re;
  logic [IW-1:0]    rd_id;
  logic [DW-1:0]    rd_data, ram_wdata, ram_rdata;
  logic [AW-1:0]    ram_waddr, ram_raddr;

  dpram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_gnt_o(wr_gnt),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
    .rd_valid_o(rd_valid), .rd_id_o(rd_id), .rd_data_o(rd_data),
    .ram_write_en_o(ram_we), .ram_write_addr_o(ram_waddr), .ram_data_o(ram_wdata),
    .ram_read_en_o(ram_re), .ram_read_addr_o(ram_raddr), .ram_data_i(ram_rdata)
  );

  // Environment RAM: combinational read, write at the clock edge.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign ram_rdata = mem[ram_raddr];
  always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;

  // Reference model state.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int wptr, rptr, exp_wg, exp_rg;
  logic          m_valid;
  int            m_id;
  logic [DW-1:0] m_data;
  logic [NR-1:0] exp_wg_v, exp_rg_v;
  logic [AW-1:0] exp_waddr, exp_raddr;
  logic [DW-1:0] exp_wdata;
  int n_pass = 0, n_total = 0;

  function automatic int pick(input logic [NR-1:0] req, input int ptr);
    for (int i = 0; i < NR; i++)
      if (req[(ptr + i) % NR]) return (ptr + i) % NR;
    return -1;
  endfunction

  // Apply inputs, settle to mid-cycle, compute expected combinational outputs.
  task automatic drive(input logic r, input logic [NR-1:0] wq, input logic [NR-1:0] rq);
    rst = r; wr_req = wq; rd_req = rq;
    #4;
    exp_wg = r ? -1 : pick(wq, wptr);
    exp_rg = r ? -1 : pick(rq, rptr);
    exp_wg_v  = (exp_wg < 0) ? '0 : (NR'(1) << exp_wg);
    exp_rg_v  = (exp_rg < 0) ? '0 : (NR'(1) << exp_rg);
    exp_waddr = (exp_wg < 0) ? '0 : wr_addr[exp_wg*AW +: AW];
    exp_wdata = (exp_wg < 0) ? '0 : wr_data[exp_wg*DW +: DW];
    exp_raddr = (exp_rg < 0) ? '0 : rd_addr[exp_rg*AW +: AW];
  endtask

  // Cross the edge, advance the model (read sees the pre-write word).
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      wptr = 0; rptr = 0; m_valid = 1'b0; m_id = 0; m_data = '0;
    end else begin
      m_valid = (exp_rg >= 0);
      if (exp_rg >= 0) begin m_id = exp_rg; m_data = ref_mem[exp_raddr]; rptr = (exp_rg + 1) % NR; end
      if (exp_wg >= 0) begin ref_mem[exp_waddr] = exp_wdata; wptr = (exp_wg + 1) % NR; end
    end
    #1;
  endtask

  task automatic do_reset();
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    drive(1'b1, '0, '0); tick();
  endtask

  task automatic test_reset();
    wr_addr = '0; wr_data = '0; rd_addr = '0;
    drive(1'b1, 4'b1111, 4'b1111);
    n_total++; if (wr_gnt !== 4'b0) $display("FAIL reset_wr_gnt got %b want 0", wr_gnt); else n_pass++;
    n_total++; if (rd_gnt !== 4'b0) $display("FAIL reset_rd_gnt got %b want 0", rd_gnt); else n_pass++;
    n_total++; if (ram_we !== 1'b0) $display("FAIL reset_ram_we got %b want 0", ram_we); else n_pass++;
    tick();
    n_total++; if ({rd_valid, rd_id, rd_data} !== '0)
      $display("FAIL reset_rd_regs got v=%b id=%0d d=%h want 0", rd_valid, rd_id, rd_data); else n_pass++;
  endtask

  task automatic test_all_req();
    int seq [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    do_reset();
    for (int k = 0; k < NR; k++) begin
      wr_addr[k*AW +: AW] = AW'(k + 1);
      wr_data[k*DW +: DW] = DW'(32'hA0 + k);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 4'b1111, 4'b0);
      n_total++; if (wr_gnt !== (4'b1 << seq[i]) || wr_gnt !== exp_wg_v)
        $display("FAIL all_req_gnt cyc %0d got %b want %b", i, wr_gnt, 4'b1 << seq[i]); else n_pass++;
      n_total++; if (ram_we !== 1'b1) $display("FAIL all_req_we cyc %0d got %b want 1", i, ram_we); else n_pass++;
      n_total++; if (ram_waddr !== exp_waddr || ram_wdata !== exp_wdata)
        $display("FAIL all_req_bus cyc %0d got %h/%h want %h/%h", i, ram_waddr, ram_wdata, exp_waddr, exp_wdata); else n_pass++;
      tick();
    end
  endtask

  task automatic test_sparse();
    int seq [3] = '{1, 3, 1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b1010, 4'b0);
      n_total++; if (wr_gnt !== (4'b1 << seq[i]))
        $display("FAIL sparse_gnt cyc %0d got %b want %b", i, wr_gnt, 4'b1 << seq[i]); else n_pass++;
      tick();
    end
  endtask

  task automatic test_write_then_read();
    do_reset();
    wr_addr[2*AW +: AW] = 10'h005; wr_data[2*DW +: DW] = 32'hDEADBEEF;
    drive(1'b0, 4'b0100, 4'b0);
    n_total++; if (ram_waddr !== 10'h005 || ram_wdata !== 32'hDEADBEEF)
      $display("FAIL wtr_wbus got %h/%h want 005/deadbeef", ram_waddr, ram_wdata); else n_pass++;
    tick();
    rd_addr[0 +: AW] = 10'h005;
    drive(1'b0, 4'b0, 4'b0001);
    n_total++; if (rd_gnt !== 4'b0001 || ram_raddr !== 10'h005)
      $display("FAIL wtr_rgnt got %b/%h want 0001/005", rd_gnt, ram_raddr); else n_pass++;
    tick();
    n_total++; if (rd_valid !== 1'b1 || rd_id !== 2'd0 || rd_data !== 32'hDEADBEEF)
      $display("FAIL wtr_resp got v=%b id=%0d d=%h want 1/0/deadbeef", rd_valid, rd_id, rd_data); else n_pass++;
    drive(1'b0, 4'b0, 4'b0); tick();
    n_total++; if (rd_valid !== 1'b0 || rd_data !== 32'hDEADBEEF)
      $display("FAIL wtr_hold got v=%b d=%h want 0/deadbeef", rd_valid, rd_data); else n_pass++;
  endtask

  task automatic test_rbw();
    do_reset();
    wr_addr[1*AW +: AW] = 10'h010; wr_data[1*DW +: DW] = 32'h1;
    rd_addr[3*AW +: AW] = 10'h010;
    drive(1'b0, 4'b0010, 4'b1000); tick();
    n_total++; if (rd_valid !== 1'b1 || rd_id !== 2'd3 || rd_data !== 32'h0)
      $display("FAIL rbw_old got v=%b id=%0d d=%h want 1/3/0", rd_valid, rd_id, rd_data); else n_pass++;
    drive(1'b0, 4'b0, 4'b1000); tick();
    n_total++; if (rd_valid !== 1'b1 || rd_data !== 32'h1)
      $display("FAIL rbw_new got v=%b d=%h want 1/1", rd_valid, rd_data); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < NR; k++) rd_addr[k*AW +: AW] = AW'(k + 1);
    drive(1'b0, 4'b0, 4'b1111); tick();
    drive(1'b0, 4'b0, 4'b1111); tick();
    drive(1'b1, 4'b0, 4'b1111);
    n_total++; if (rd_gnt !== 4'b0 || ram_re !== 1'b0)
      $display("FAIL rstmid_gnt got %b/%b want 0/0", rd_gnt, ram_re); else n_pass++;
    tick();
    n_total++; if (rd_valid !== 1'b0 || rd_data !== '0)
      $display("FAIL rstmid_valid got v=%b d=%h want 0/0", rd_valid, rd_data); else n_pass++;
    drive(1'b0, 4'b0, 4'b1111);
    n_total++; if (rd_gnt !== 4'b0001)
      $display("FAIL rstmid_restart got %b want 0001", rd_gnt); else n_pass++;
    tick();
    n_total++; if (rd_valid !== 1'b1 || rd_id !== 2'd0 || rd_data !== ref_mem[1])
      $display("FAIL rstmid_resp got v=%b id=%0d d=%h want 1/0/%h", rd_valid, rd_id, rd_data, ref_mem[1]); else n_pass++;
  endtask

  task automatic test_random();
    logic [NR-1:0] wq = '0, rq = '0;
    int wwait [NR], rwait [NR];
    do_reset();
    for (int k = 0; k < NR; k++) begin wwait[k] = 0; rwait[k] = 0; end
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < NR; k++) begin
        if (!wq[k] && $urandom_range(1) == 1) begin
          wq[k] = 1'b1; wr_addr[k*AW +: AW] = AW'($urandom_range(15));
          wr_data[k*DW +: DW] = DW'($urandom);
        end
        if (!rq[k] && $urandom_range(1) == 1) begin
          rq[k] = 1'b1; rd_addr[k*AW +: AW] = AW'($urandom_range(15));
        end
      end
      drive(1'b0, wq, rq);
      n_total++; if (wr_gnt !== exp_wg_v || rd_gnt !== exp_rg_v)
        $display("FAIL rand_gnt cyc %0d got %b/%b want %b/%b", c, wr_gnt, rd_gnt, exp_wg_v, exp_rg_v); else n_pass++;
      n_total++; if (ram_we !== (exp_wg >= 0) || ram_waddr !== exp_waddr || ram_wdata !== exp_wdata)
        $display("FAIL rand_wbus cyc %0d got %b %h %h want %b %h %h", c, ram_we, ram_waddr, ram_wdata,
                 exp_wg >= 0, exp_waddr, exp_wdata); else n_pass++;
      n_total++; if (ram_re !== (exp_rg >= 0) || ram_raddr !== exp_raddr)
        $display("FAIL rand_rbus cyc %0d got %b %h want %b %h", c, ram_re, ram_raddr, exp_rg >= 0, exp_raddr); else n_pass++;
      for (int k = 0; k < NR; k++) begin
        if (wq[k]) begin
          if (wr_gnt[k]) begin
            n_total++; if (wwait[k] > 3) $display("FAIL rand_wfair req %0d waited %0d want <=3", k, wwait[k]); else n_pass++;
            wwait[k] = 0; wq[k] = 1'b0;
          end else wwait[k]++;
        end
        if (rq[k]) begin
          if (rd_gnt[k]) begin
            n_total++; if (rwait[k] > 3) $display("FAIL rand_rfair req %0d waited %0d want <=3", k, rwait[k]); else n_pass++;
            rwait[k] = 0; rq[k] = 1'b0;
          end else rwait[k]++;
        end
      end
      tick();
      n_total++; if (rd_valid !== m_valid || (m_valid && (rd_id !== IW'(m_id) || rd_data !== m_data)))
        $display("FAIL rand_resp cyc %0d got v=%b id=%0d d=%h want v=%b id=%0d d=%h",
                 c, rd_valid, rd_id, rd_data, m_valid, m_id, m_data); else n_pass++;
    end
  endtask

  initial begin
    for (int a = 0; a < (1<<AW); a++) begin mem[a] = '0; ref_mem[a] = '0; end
    wptr = 0; rptr = 0; m_valid = 1'b0; m_id = 0; m_data = '0;
    wr_req = '0; rd_req = '0;
    @(posedge clk); #1;
    test_reset();
    test_all_req();
    test_sparse();
    test_write_then_read();
    test_rbw();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
